mips_multicycle_ctrl: RTL
=========================

# mips_multicycle_ctrl

Multi-cycle control FSM for the MIPS core. It sequences each instruction through fetch, decode, execute, memory and writeback. It drives the 3-bit ALU operation code and the datapath enables, and consumes the ALU `zero` flag and a memory-ready handshake. It sits between the instruction register and the shared datapath, and replaces the combinational main/ALU decoders of the single-cycle build.

## Interface
- `OP_W`, 6: opcode field width.
- `FN_W`, 6: funct field width.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `opcode` in 6: instr[31:26], valid from DECODE onward.
- `funct` in 6: instr[5:0].
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory completes the current read/write this cycle.
- `alu_control` out 3: 0 AND, 1 OR, 2 ADD, 4 SLL, 6 SUB, 7 SLT.
- `alu_src_a` out 1: 0 = PC, 1 = regA.
- `alu_src_b` out 2: 00 regB, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2.
- `pc_source` out 2: 00 ALU result, 01 ALUOut, 10 jump target.
- `pc_en` out 1: PC load, equal to `pc_write | (pc_write_cond & zero)`.
- `i_or_d`, `mem_read`, `mem_write`, `ir_write`, `reg_write`, `reg_dst`, `mem_to_reg` out 1 each: standard multi-cycle datapath controls.
- `illegal_op` out 1: one-cycle pulse for an unsupported opcode or funct.
- `state` out 4: current state, for debug.
- `instr_count` out 32: count of retired instructions.

## Operation
- Reset (`rst_n`=0) forces:
  - `state` = RESET(13) and `instr_count` = 0, asynchronously.
  - Every output = 0, except `alu_control` = 2.
- RESET has all outputs 0 and always goes to FETCH.
- Outputs are a Moore decode of the state, with two exceptions: `ir_write`/`pc_write` in FETCH, and `pc_en`. Any control not listed for a state is 0, and `alu_control` defaults to 2.
- FETCH(0):
  - `mem_read`=1, `i_or_d`=0, src_a=0, src_b=01, ADD, `pc_source`=00.
  - `ir_write` and `pc_write` equal `mem_ready`.
  - Stays in FETCH until `mem_ready`, then goes to DECODE.
- DECODE(1): src_a=0, src_b=11, ADD (branch target into ALUOut). Next state by opcode:
  - 0x00 → EXEC_R.
  - 0x23 or 0x2B → MEM_ADDR.
  - 0x04 → BRANCH.
  - 0x02 → JUMP.
  - 0x08 → ADDI_EX.
  - Anything else → ILLEGAL.
- MEM_ADDR(2): src_a=1, src_b=10, ADD. Goes to MEM_RD for lw, MEM_WR for sw.
- MEM_RD(3): `mem_read`=1, `i_or_d`=1. Holds until `mem_ready`, then goes to MEM_WB.
- MEM_WB(4): `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0. Goes to FETCH.
- MEM_WR(5): `mem_write`=1, `i_or_d`=1. Holds until `mem_ready`, then goes to FETCH.
- EXEC_R(6): src_a=1, src_b=00. `alu_control` by funct:
  - 0x24 → 0, 0x25 → 1, 0x20 → 2, 0x00 → 4, 0x22 → 6, 0x2A → 7.
  - Any other funct → ILLEGAL instead of RTYPE_WB.
- RTYPE_WB(7): `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0. Goes to FETCH.
- BRANCH(8): src_a=1, src_b=00, SUB, `pc_write_cond`=1, `pc_source`=01. Goes to FETCH.
- JUMP(9): `pc_write`=1, `pc_source`=10. Goes to FETCH.
- ADDI_EX(10): src_a=1, src_b=10, ADD. Goes to ADDI_WB.
- ADDI_WB(11): `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0. Goes to FETCH.
- ILLEGAL(12): `illegal_op`=1. Goes to FETCH. The instruction does not retire and performs no writes.
- `instr_count` increments by 1 on each transition into FETCH from states 4, 5, 7, 8, 9 or 11. It wraps 0xFFFFFFFF → 0.

## Timing
- Instruction latencies, with `mem_ready` tied high:
  - R-type 4 cycles; addi 4; beq 3; j 3.
  - lw 5; sw 4.
- Each cycle `mem_ready` is low in FETCH, MEM_RD or MEM_WR adds one cycle. Strobes stay asserted throughout the wait.
- `mem_ready` is ignored in all other states.
- `pc_en` is combinational from `zero` in BRANCH, so a taken beq loads the PC at the end of BRANCH.
- `instr_count` updates on the same edge that enters FETCH.
- `illegal_op` is high for exactly the ILLEGAL cycle.
- Reset asserted mid-instruction aborts it immediately: no write strobes stay high after `rst_n` falls.
- After release, the first FETCH is two edges later (RESET, then FETCH).

## Structure
- Package `mips_ctrl_pkg` holds:
  - State encodings.
  - ALU codes: AND=0, OR=1, ADD=2, SLL=4, SUB=6, SLT=7.
  - Opcode and funct constants.
  - src_b and pc_source encodings.
- One sub-module, `alu_op_decode`: a combinational funct → {alu_control, valid} map used by EXEC_R.
- The FSM holds only the state register and `instr_count`.

## Test plan
- Reset held, then released, with `mem_ready`=1 → `state` goes 13, 0, 1. All write strobes are 0 during reset.
- R-type add (op 0x00, funct 0x20) → EXEC_R drives `alu_control`=2. RTYPE_WB has `reg_write`=1 and `reg_dst`=1. `instr_count` becomes 1 after 4 cycles.
- beq (op 0x04) with `zero`=1, then with `zero`=0 → `pc_en`=1 and then 0 in BRANCH, with `alu_control`=6 in both cases.
- lw with `mem_ready` low for 3 cycles in MEM_RD → `mem_read`/`i_or_d` stay high for 4 cycles. Total latency is 8 cycles, and `mem_to_reg`=1 in MEM_WB.
- Unsupported opcode 0x3F, and R-type with funct 0x27 → `illegal_op` pulses once, the FSM returns to FETCH, and `instr_count` is unchanged.
- Force `instr_count` to 0xFFFFFFFF, then retire a j → `instr_count` becomes 0. Separately, assert `rst_n`=0 during MEM_WR → `mem_write` drops in the same cycle.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// mips_ctrl_pkg : state, ALU, opcode/funct and mux encodings for the
//                 multi-cycle MIPS controller.          Rev 1.0
// ============================================================================
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEM_ADDR = 4'd2,
    ST_MEM_RD   = 4'd3,
    ST_MEM_WB   = 4'd4,
    ST_MEM_WR   = 4'd5,
    ST_EXEC_R   = 4'd6,
    ST_RTYPE_WB = 4'd7,
    ST_BRANCH   = 4'd8,
    ST_JUMP     = 4'd9,
    ST_ADDI_EX  = 4'd10,
    ST_ADDI_WB  = 4'd11,
    ST_ILLEGAL  = 4'd12,
    ST_RESET    = 4'd13
  } state_t;

  localparam logic [2:0] c_alu_and = 3'd0;
  localparam logic [2:0] c_alu_or  = 3'd1;
  localparam logic [2:0] c_alu_add = 3'd2;
  localparam logic [2:0] c_alu_sll = 3'd4;
  localparam logic [2:0] c_alu_sub = 3'd6;
  localparam logic [2:0] c_alu_slt = 3'd7;

  localparam logic [5:0] c_op_rtype = 6'h00;
  localparam logic [5:0] c_op_lw    = 6'h23;
  localparam logic [5:0] c_op_sw    = 6'h2B;
  localparam logic [5:0] c_op_beq   = 6'h04;
  localparam logic [5:0] c_op_j     = 6'h02;
  localparam logic [5:0] c_op_addi  = 6'h08;

  localparam logic [5:0] c_fn_and = 6'h24;
  localparam logic [5:0] c_fn_or  = 6'h25;
  localparam logic [5:0] c_fn_add = 6'h20;
  localparam logic [5:0] c_fn_sll = 6'h00;
  localparam logic [5:0] c_fn_sub = 6'h22;
  localparam logic [5:0] c_fn_slt = 6'h2A;

  localparam logic [1:0] c_srcb_reg    = 2'b00;
  localparam logic [1:0] c_srcb_four   = 2'b01;
  localparam logic [1:0] c_srcb_imm    = 2'b10;
  localparam logic [1:0] c_srcb_imm_sh = 2'b11;

  localparam logic [1:0] c_pcsrc_alu    = 2'b00;
  localparam logic [1:0] c_pcsrc_aluout = 2'b01;
  localparam logic [1:0] c_pcsrc_jump   = 2'b10;

endpackage
`default_nettype wire

// File: rtl/mips_multicycle_ctrl_alu_op_decode.sv
`default_nettype none
// ============================================================================
// alu_op_decode : R-type funct field to ALU operation map.      Rev 1.0
// ============================================================================
module alu_op_decode
  import mips_ctrl_pkg::*;
#(
  parameter int FN_W = 6
) (
  input  logic [FN_W-1:0] funct,
  output logic [2:0]      alu_control,
  output logic            valid
);

  always_comb begin
    alu_control = c_alu_add;
    valid       = 1'b1;
    case (funct)
      FN_W'(c_fn_and): alu_control = c_alu_and;
      FN_W'(c_fn_or):  alu_control = c_alu_or;
      FN_W'(c_fn_add): alu_control = c_alu_add;
      FN_W'(c_fn_sll): alu_control = c_alu_sll;
      FN_W'(c_fn_sub): alu_control = c_alu_sub;
      FN_W'(c_fn_slt): alu_control = c_alu_slt;
      default:         valid       = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// mips_multicycle_ctrl : multi-cycle MIPS control FSM with retired-instruction
//                        counter.                                 Rev 1.0
// ============================================================================
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int OP_W = 6,
  parameter int FN_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OP_W-1:0] opcode,
  input  logic [FN_W-1:0] funct,
  input  logic            zero,
  input  logic            mem_ready,
  output logic [2:0]      alu_control,
  output logic            alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic [1:0]      pc_source,
  output logic            pc_en,
  output logic            i_or_d,
  output logic            mem_read,
  output logic            mem_write,
  output logic            ir_write,
  output logic            reg_write,
  output logic            reg_dst,
  output logic            mem_to_reg,
  output logic            illegal_op,
  output logic [3:0]      state,
  output logic [31:0]     instr_count
);

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_instr_count;
  logic        w_pc_write;
  logic        w_pc_write_cond;
  logic        w_retire;
  logic [2:0]  w_fn_alu;
  logic        w_fn_valid;

  alu_op_decode #(
    .FN_W(FN_W)
  ) u_alu_op_decode (
    .funct      (funct),
    .alu_control(w_fn_alu),
    .valid      (w_fn_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_RESET;
      r_instr_count <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_retire)
        r_instr_count <= r_instr_count + 32'd1;
    end
  end

  always_comb begin
    w_next_state    = r_state;
    alu_control     = c_alu_add;
    alu_src_a       = 1'b0;
    alu_src_b       = c_srcb_reg;
    pc_source       = c_pcsrc_alu;
    w_pc_write      = 1'b0;
    w_pc_write_cond = 1'b0;
    i_or_d          = 1'b0;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    ir_write        = 1'b0;
    reg_write       = 1'b0;
    reg_dst         = 1'b0;
    mem_to_reg      = 1'b0;
    illegal_op      = 1'b0;
    case (r_state)
      ST_RESET: w_next_state = ST_FETCH;
      ST_FETCH: begin
        mem_read   = 1'b1;
        alu_src_b  = c_srcb_four;
        ir_write   = mem_ready;
        w_pc_write = mem_ready;
        if (mem_ready)
          w_next_state = ST_DECODE;
      end
      ST_DECODE: begin
        alu_src_b = c_srcb_imm_sh;
        case (opcode)
          OP_W'(c_op_rtype):          w_next_state = ST_EXEC_R;
          OP_W'(c_op_lw),
          OP_W'(c_op_sw):             w_next_state = ST_MEM_ADDR;
          OP_W'(c_op_beq):            w_next_state = ST_BRANCH;
          OP_W'(c_op_j):              w_next_state = ST_JUMP;
          OP_W'(c_op_addi):           w_next_state = ST_ADDI_EX;
          default:                    w_next_state = ST_ILLEGAL;
        endcase
      end
      ST_MEM_ADDR: begin
        alu_src_a    = 1'b1;
        alu_src_b    = c_srcb_imm;
        w_next_state = (opcode == OP_W'(c_op_lw)) ? ST_MEM_RD : ST_MEM_WR;
      end
      ST_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready)
          w_next_state = ST_MEM_WB;
      end
      ST_MEM_WB: begin
        reg_write    = 1'b1;
        mem_to_reg   = 1'b1;
        w_next_state = ST_FETCH;
      end
      ST_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready)
          w_next_state = ST_FETCH;
      end
      ST_EXEC_R: begin
        alu_src_a    = 1'b1;
        alu_control  = w_fn_alu;
        w_next_state = w_fn_valid ? ST_RTYPE_WB : ST_ILLEGAL;
      end
      ST_RTYPE_WB: begin
        reg_write    = 1'b1;
        reg_dst      = 1'b1;
        w_next_state = ST_FETCH;
      end
      ST_BRANCH: begin
        alu_src_a       = 1'b1;
        alu_control     = c_alu_sub;
        w_pc_write_cond = 1'b1;
        pc_source       = c_pcsrc_aluout;
        w_next_state    = ST_FETCH;
      end
      ST_JUMP: begin
        w_pc_write   = 1'b1;
        pc_source    = c_pcsrc_jump;
        w_next_state = ST_FETCH;
      end
      ST_ADDI_EX: begin
        alu_src_a    = 1'b1;
        alu_src_b    = c_srcb_imm;
        w_next_state = ST_ADDI_WB;
      end
      ST_ADDI_WB: begin
        reg_write    = 1'b1;
        w_next_state = ST_FETCH;
      end
      ST_ILLEGAL: begin
        illegal_op   = 1'b1;
        w_next_state = ST_FETCH;
      end
      default: w_next_state = ST_RESET;
    endcase
  end

  // Only completed instructions retire; ILLEGAL and RESET return to FETCH uncounted.
  always_comb begin
    w_retire = 1'b0;
    if (w_next_state == ST_FETCH) begin
      case (r_state)
        ST_MEM_WB, ST_MEM_WR, ST_RTYPE_WB,
        ST_BRANCH, ST_JUMP, ST_ADDI_WB: w_retire = 1'b1;
        default:                        w_retire = 1'b0;
      endcase
    end
  end

  assign pc_en       = w_pc_write | (w_pc_write_cond & zero);
  assign state       = r_state;
  assign instr_count = r_instr_count;

endmodule
`default_nettype wire
